branch_pc_unit: RTL and testbench
=================================

// Module: branch_pc_unit
// PURPOSE
//   Program-counter and branch-resolution stage of KGP-RISC. Sits directly downstream of the ALU.
//   Registers the ALU carry flag and resolves b/bl/br/bltz/bz/bnz/bcy/bncy.
//   Holds the PC register and produces next-PC, link write-back and taken indication for fetch and regfile.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset
//   PC_STEP   32'd4          sequential PC increment (byte-addressed, word instructions)
// PORTS
//   clk          in   1   single system clock, all state updates on rising edge
//   rst          in   1   synchronous, active-high reset
//   stall        in   1   1 = freeze PC and carry register, suppress link_we
//   branch_op    in   4   0000 none,0001 b,0010 bl,0011 br,0100 bltz,0101 bz,0110 bnz,0111 bcy,1000 bncy; others = none
//   target       in   32  absolute branch target (label form)
//   rs_val       in   32  source register value: condition operand (bltz/bz/bnz), jump address (br)
//   alu_flag     in   1   ALU carry-out; meaningful only for add-class ops
//   flag_we      in   1   1 = current instruction updates the carry register (add/addi class)
//   pc           out  32  current PC (registered)
//   pc_plus4     out  32  pc + PC_STEP (combinational)
//   next_pc      out  32  PC to be loaded at next edge (combinational)
//   taken        out  1   branch resolved taken this cycle (combinational)
//   link_we      out  1   regfile write strobe for ra on bl (combinational)
//   link_addr    out  32  value for ra = pc_plus4
//   carry        out  1   registered carry flag
// BEHAVIOUR
//   - Reset (rst=1 at edge): pc<=RESET_PC, carry<=0. rst has priority over stall and all inputs.
//   - Combinational outputs follow their equations during reset; link_we additionally forced 0 while rst=1.
//   - Condition eval, combinational same cycle:
//     - b/bl/br: always taken.
//     - bltz: rs_val[31]==1.
//     - bz: rs_val==0.
//     - bnz: rs_val!=0.
//     - bcy: carry==1.
//     - bncy: carry==0.
//     - none/undefined codes: taken=0.
//   - Target select: br -> rs_val, else -> target; selected target has [1:0] forced to 2'b00.
//   - next_pc = taken ? selected_target : pc_plus4. pc_plus4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
//   - Edge update, rst=0 and stall=0: pc<=next_pc; if flag_we, carry<=alu_flag.
//   - Edge update, rst=0 and stall=1: pc and carry hold; taken still reflects the condition, but no state changes.
//   - bcy/bncy evaluate the registered carry, i.e. from the last completed flag_we instruction.
//     - flag_we and a carry branch in the same cycle: branch uses the old carry; the new value is visible next cycle.
//   - Latency: branch resolves in 0 cycles (same cycle); PC redirect visible on pc 1 cycle later; no delay slot.
//   - link_we = (branch_op==bl) & ~stall & ~rst. link_addr = pc_plus4 of the bl instruction itself.
//   - flag_we with stall=1: flag update dropped; upstream re-presents the instruction when stall falls.
// TESTING
//   1 rst=1 two cycles, then rst=0, branch_op=0, 3 edges -> pc 0,4,8,12; carry=0.
//   2 pc=8, branch_op=bl, target=32'h40 -> taken=1, link_we=1, link_addr=12; next edge pc=32'h40.
//   3 add-class op: alu_flag=1 (0xFFFFFFFF+1), flag_we=1; bcy same cycle not taken; carry=1 next cycle; bcy target 0x80 -> pc=0x80.
//   4 bz rs_val=0 / bnz rs_val=5 / bltz rs_val=32'h8000_0000 -> all taken; bz rs_val=1 -> not taken, pc+4.
//   5 br rs_val=32'h0000_0107 -> pc=32'h104. stall=1 for 3 cycles -> pc, carry constant, link_we=0.
//   6 pc=32'hFFFF_FFFC, branch_op=0 -> pc=0. rst asserted mid-stall with taken branch -> pc=RESET_PC, carry=0.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Program-counter and branch-resolution stage. Holds the PC and the registered
// ALU carry flag, resolves branch conditions in the same cycle and produces the
// next PC, the taken indication and the link write-back for bl.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [3:0]  branch_op,
    input  logic [31:0] target,
    input  logic [31:0] rs_val,
    input  logic        alu_flag,
    input  logic        flag_we,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        taken,
    output logic        link_we,
    output logic [31:0] link_addr,
    output logic        carry
);

    localparam logic [3:0] OP_B    = 4'b0001;
    localparam logic [3:0] OP_BL   = 4'b0010;
    localparam logic [3:0] OP_BR   = 4'b0011;
    localparam logic [3:0] OP_BLTZ = 4'b0100;
    localparam logic [3:0] OP_BZ   = 4'b0101;
    localparam logic [3:0] OP_BNZ  = 4'b0110;
    localparam logic [3:0] OP_BCY  = 4'b0111;
    localparam logic [3:0] OP_BNCY = 4'b1000;

    logic [31:0] sel_target;

    // Branch condition evaluation; carry branches see the registered flag,
    // so a flag update in the same cycle only affects the following branch.
    always_comb begin
        taken = 1'b0;
        case (branch_op)
            OP_B, OP_BL, OP_BR: taken = 1'b1;
            OP_BLTZ:            taken = rs_val[31];
            OP_BZ:              taken = (rs_val == 32'd0);
            OP_BNZ:             taken = (rs_val != 32'd0);
            OP_BCY:             taken = carry;
            OP_BNCY:            taken = ~carry;
            default:            taken = 1'b0;
        endcase
    end

    // Target select and next-PC; targets are word aligned by dropping [1:0].
    always_comb begin
        pc_plus4   = pc + PC_STEP;
        sel_target = (branch_op == OP_BR) ? rs_val : target;
        sel_target[1:0] = 2'b00;
        next_pc    = taken ? sel_target : pc_plus4;
        link_addr  = pc_plus4;
        link_we    = (branch_op == OP_BL) & ~stall & ~rst;
    end

    // PC and carry state; reset wins over stall, stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            carry <= 1'b0;
        end else if (!stall) begin
            pc <= next_pc;
            if (flag_we)
                carry <= alu_flag;
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed-vector bench for branch_pc_unit with hand-computed expectations.
module tb_branch_pc_unit;

    logic        clk = 1'b0;
    logic        rst, stall, alu_flag, flag_we;
    logic [3:0]  branch_op;
    logic [31:0] target, rs_val;
    logic [31:0] pc, pc_plus4, next_pc, link_addr;
    logic        taken, link_we, carry;

    int n_chk  = 0;
    int n_fail = 0;

    branch_pc_unit #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_op(branch_op),
        .target(target), .rs_val(rs_val), .alu_flag(alu_flag), .flag_we(flag_we),
        .pc(pc), .pc_plus4(pc_plus4), .next_pc(next_pc), .taken(taken),
        .link_we(link_we), .link_addr(link_addr), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then let outputs settle before the next check.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] tgt, input logic [31:0] rs);
        branch_op = op;
        target    = tgt;
        rs_val    = rs;
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; alu_flag = 1'b0; flag_we = 1'b0;
        branch_op = 4'd0; target = 32'h0; rs_val = 32'h0;
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        drive(4'b0010, 32'h40, 32'h0);
        chk("rst_link_we", {31'd0, link_we}, 32'd0);
        drive(4'd0, 32'h0, 32'h0);
        rst = 1'b0;
        tick(); chk("seq_pc1", pc, 32'h4);
        tick(); chk("seq_pc2", pc, 32'h8);
        tick(); chk("seq_pc3", pc, 32'hC);
        chk("seq_carry", {31'd0, carry}, 32'd0);

        // bl from pc=0xC
        drive(4'b0010, 32'h40, 32'h0);
        chk("bl_taken", {31'd0, taken}, 32'd1);
        chk("bl_link_we", {31'd0, link_we}, 32'd1);
        chk("bl_link_addr", link_addr, 32'h10);
        chk("bl_next_pc", next_pc, 32'h40);
        tick(); chk("bl_pc", pc, 32'h40);

        // carry written and bcy in the same cycle: old carry (0) used
        drive(4'b0111, 32'h80, 32'h0);
        flag_we = 1'b1; alu_flag = 1'b1; #1;
        chk("bcy_old_taken", {31'd0, taken}, 32'd0);
        chk("bcy_old_next", next_pc, 32'h44);
        tick();
        flag_we = 1'b0; alu_flag = 1'b0; #1;
        chk("carry_set", {31'd0, carry}, 32'd1);
        chk("pc_44", pc, 32'h44);
        drive(4'b1000, 32'h80, 32'h0);
        chk("bncy_not", {31'd0, taken}, 32'd0);
        drive(4'b0111, 32'h80, 32'h0);
        chk("bcy_taken", {31'd0, taken}, 32'd1);
        tick(); chk("bcy_pc", pc, 32'h80);

        // register-condition branches
        drive(4'b0101, 32'h100, 32'h0);
        chk("bz_taken", {31'd0, taken}, 32'd1);
        tick(); chk("bz_pc", pc, 32'h100);
        drive(4'b0110, 32'h202, 32'h5);
        chk("bnz_align", next_pc, 32'h200);
        tick(); chk("bnz_pc", pc, 32'h200);
        drive(4'b0100, 32'h300, 32'h8000_0000);
        tick(); chk("bltz_pc", pc, 32'h300);
        drive(4'b0100, 32'h400, 32'h7FFF_FFFF);
        chk("bltz_pos", {31'd0, taken}, 32'd0);
        drive(4'b0101, 32'h500, 32'h1);
        chk("bz_nz", {31'd0, taken}, 32'd0);
        tick(); chk("bz_nt_pc", pc, 32'h304);
        drive(4'b1111, 32'h500, 32'h0);
        chk("undef_op", {31'd0, taken}, 32'd0);

        // br uses rs_val, aligned
        drive(4'b0011, 32'h999, 32'h107);
        chk("br_next", next_pc, 32'h104);
        tick(); chk("br_pc", pc, 32'h104);

        // stall with bl and a pending flag clear: nothing moves
        stall = 1'b1; flag_we = 1'b1; alu_flag = 1'b0;
        drive(4'b0010, 32'h500, 32'h0);
        chk("stall_link_we", {31'd0, link_we}, 32'd0);
        chk("stall_taken", {31'd0, taken}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc, 32'h104);
            chk("stall_carry", {31'd0, carry}, 32'd1);
        end
        stall = 1'b0; flag_we = 1'b0;

        // wrap at the top of the address space
        drive(4'b0011, 32'h0, 32'hFFFF_FFFC);
        tick(); chk("top_pc", pc, 32'hFFFF_FFFC);
        drive(4'd0, 32'h0, 32'h0);
        chk("wrap_plus4", pc_plus4, 32'h0);
        tick(); chk("wrap_pc", pc, 32'h0);

        // reset during stall with a taken branch
        drive(4'b0001, 32'h600, 32'h0);
        tick(); chk("b_pc", pc, 32'h600);
        stall = 1'b1;
        drive(4'b0001, 32'h700, 32'h0);
        tick(); chk("stall_b_pc", pc, 32'h600);
        rst = 1'b1; #1;
        tick();
        chk("rst_stall_pc", pc, 32'h0);
        chk("rst_stall_carry", {31'd0, carry}, 32'd0);
        rst = 1'b0; stall = 1'b0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
